irom_access_arbiter: RTL and testbench
======================================

// Module: irom_access_arbiter
// PURPOSE
//  Shares the single-port instruction memory (sync RAM, 1-cycle read latency) between the
//  CPU fetch port and the program-loader/debug port. Sequences boot: CPU fetch is held off
//  until the loader signals program load complete.
//  Sits between the IF stage / loader and the instruction RAM macro (cs/we/addr/wdata/rdata).
// PARAMETERS
//  IROM_SPACE    4096  memory depth in 32-bit words; ADDR_WIDTH = $clog2(IROM_SPACE) (localparam)
//  LD_BURST_MAX  8     consecutive loader grants allowed while cpu_req pending (>=1)
// PORTS
//  clk        in   1          system clock
//  rstn       in   1          async active-low reset
//  boot_done  in   1          1-cycle pulse: program load complete, enter RUN
//  cpu_req    in   1          CPU fetch request
//  cpu_addr   in   32         CPU byte address
//  cpu_ready  out  1          CPU request accepted this cycle
//  cpu_rvalid out  1          CPU read data valid
//  cpu_rdata  out  32         CPU read data
//  cpu_err    out  1          with cpu_rvalid: address out of range
//  ld_req     in   1          loader request
//  ld_we      in   4          loader byte write enables (0 = read)
//  ld_addr    in   32         loader byte address
//  ld_wdata   in   32         loader write data
//  ld_ready   out  1          loader request accepted this cycle
//  ld_rvalid  out  1          loader read data valid (reads only)
//  ld_rdata   out  32         loader read data
//  mem_cs     out  1          RAM chip select
//  mem_we     out  4          RAM byte write enables
//  mem_addr   out  ADDR_WIDTH RAM word address
//  mem_wdata  out  32         RAM write data
//  mem_rdata  in   32         RAM read data (valid cycle after cs with we==0)
// BEHAVIOUR
//  - FSM: BOOT (reset state) -> RUN on boot_done; RUN is terminal until reset.
//  - BOOT: cpu_ready=0; loader has exclusive access.
//  - RUN: loader priority, except when burst counter == LD_BURST_MAX and cpu_req=1 -> CPU granted.
//  - Burst counter: +1 per loader grant while cpu_req=1 (saturates); cleared on CPU grant or cpu_req=0.
//  - Grant is combinational same cycle: ready=1 iff req=1 and port wins; at most one ready per cycle.
//  - Word address = addr[ADDR_WIDTH+1:2]; addr[1:0] ignored.
//  - Out of range (addr[31:ADDR_WIDTH+2]!=0): request accepted but mem_cs=0; for CPU, cpu_rvalid=1,
//    cpu_err=1, cpu_rdata=0 next cycle; loader write dropped; loader read returns ld_rvalid, rdata 0.
//  - mem_cs=1 only on an in-range grant; mem_we=ld_we for loader, 0 for CPU; idle: mem_* all 0.
//  - Read latency exactly 1: owner register records granted read port; next cycle that port's
//    rvalid=1, rdata=mem_rdata. Back-to-back grants give back-to-back rvalid. Writes: no rvalid.
//  - rdata outputs 0 whenever their rvalid=0.
//  - Reset (any time, incl. mid-read): all outputs 0, FSM=BOOT, counter=0, pending rvalid dropped.
//  - boot_done in RUN: ignored. boot_done with simultaneous cpu_req: CPU not granted until next cycle.
// CONFIGURATION
//  IROM_BOOT_BYPASS_EN: defined -> FSM resets to RUN, boot_done ignored, CPU fetches immediately
//  after reset release (ROM preloaded). Undefined -> BOOT phase as above.
// TESTING
//  - Reset, cpu_req=1 addr 0x0 in BOOT -> cpu_ready=0 for 10 cycles; pulse boot_done -> next cycle ready=1.
//  - Loader write we=4'hF addr 0x10 data 0xDEADBEEF, loader read 0x10 -> ld_rvalid 1 cycle later,
//    ld_rdata=0xDEADBEEF; mem_addr=4.
//  - RUN, ld_req and cpu_req held high -> 8 loader grants then 1 CPU grant, pattern repeats.
//  - CPU read addr 0x4000 (IROM_SPACE=4096) -> cpu_ready=1, mem_cs=0, next cycle rvalid=1, err=1, rdata=0.
//  - CPU read granted, rstn low before rvalid cycle -> no cpu_rvalid; after release FSM=BOOT.
//  - IROM_BOOT_BYPASS_EN defined: cpu_req at first cycle after reset -> cpu_ready=1 without boot_done.

Source files
------------

// File: rtl/irom_access_arbiter.sv
// rtl/irom_access_arbiter.sv - shares the instruction RAM between CPU fetch and loader with boot sequencing
// Define IROM_BOOT_BYPASS_EN to start in RUN and ignore boot_done (memory preloaded).
module irom_access_arbiter #(
   parameter int  IROM_SPACE   = 4096,
   parameter int  LD_BURST_MAX = 8,
   localparam int ADDR_WIDTH   = $clog2(IROM_SPACE)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  boot_done,
   input  logic                  cpu_req,
   input  logic [31:0]           cpu_addr,
   output logic                  cpu_ready,
   output logic                  cpu_rvalid,
   output logic [31:0]           cpu_rdata,
   output logic                  cpu_err,
   input  logic                  ld_req,
   input  logic [3:0]            ld_we,
   input  logic [31:0]           ld_addr,
   input  logic [31:0]           ld_wdata,
   output logic                  ld_ready,
   output logic                  ld_rvalid,
   output logic [31:0]           ld_rdata,
   output logic                  mem_cs,
   output logic [3:0]            mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata
);

   localparam int CW = $clog2(LD_BURST_MAX + 1);

   typedef enum logic {ST_BOOT, ST_RUN} state_t;

`ifdef IROM_BOOT_BYPASS_EN
   localparam state_t RESET_STATE = ST_RUN;
   logic unused_in;
   assign unused_in = ^{cpu_addr[1:0], ld_addr[1:0], boot_done};
`else
   localparam state_t RESET_STATE = ST_BOOT;
   logic unused_in;
   assign unused_in = ^{cpu_addr[1:0], ld_addr[1:0]};
`endif

   state_t        state_q, state_d;
   logic [CW-1:0] burst_q, burst_d;
   logic          cpu_pend_q, cpu_pend_d, cpu_oor_q, cpu_oor_d;
   logic          ld_pend_q, ld_pend_d, ld_oor_q, ld_oor_d;
   logic          cpu_gnt, ld_gnt, cpu_in_range, ld_in_range, burst_full;

   assign cpu_in_range = (cpu_addr[31:ADDR_WIDTH+2] == '0);
   assign ld_in_range  = (ld_addr[31:ADDR_WIDTH+2] == '0);
   assign burst_full   = (burst_q == CW'(LD_BURST_MAX));

   always_comb begin
      state_d    = state_q;
      burst_d    = burst_q;
      cpu_gnt    = 1'b0;
      ld_gnt     = 1'b0;
      cpu_pend_d = 1'b0;
      cpu_oor_d  = 1'b0;
      ld_pend_d  = 1'b0;
      ld_oor_d   = 1'b0;
      mem_cs     = 1'b0;
      mem_we     = '0;
      mem_addr   = '0;
      mem_wdata  = '0;

      // Grants are gated by rstn so every output is quiet while reset is held.
      if (rstn) begin
         case (state_q)
            ST_BOOT: begin
               ld_gnt  = ld_req;
               burst_d = '0;
`ifndef IROM_BOOT_BYPASS_EN
               if (boot_done) state_d = ST_RUN;
`endif
            end
            default: begin
               cpu_gnt = cpu_req && (!ld_req || burst_full);
               ld_gnt  = ld_req && !cpu_gnt;
               if (cpu_gnt || !cpu_req) burst_d = '0;
               else if (ld_gnt && !burst_full) burst_d = burst_q + 1'b1;
            end
         endcase
      end

      if (cpu_gnt) begin
         cpu_pend_d = 1'b1;
         cpu_oor_d  = !cpu_in_range;
         if (cpu_in_range) begin
            mem_cs   = 1'b1;
            mem_addr = cpu_addr[ADDR_WIDTH+1:2];
         end
      end

      if (ld_gnt) begin
         ld_pend_d = (ld_we == 4'h0);
         ld_oor_d  = !ld_in_range;
         if (ld_in_range) begin
            mem_cs    = 1'b1;
            mem_we    = ld_we;
            mem_addr  = ld_addr[ADDR_WIDTH+1:2];
            mem_wdata = ld_wdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= RESET_STATE;
         burst_q    <= '0;
         cpu_pend_q <= 1'b0;
         cpu_oor_q  <= 1'b0;
         ld_pend_q  <= 1'b0;
         ld_oor_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         burst_q    <= burst_d;
         cpu_pend_q <= cpu_pend_d;
         cpu_oor_q  <= cpu_oor_d;
         ld_pend_q  <= ld_pend_d;
         ld_oor_q   <= ld_oor_d;
      end
   end

   assign cpu_ready  = cpu_gnt;
   assign ld_ready   = ld_gnt;
   assign cpu_rvalid = cpu_pend_q;
   assign cpu_err    = cpu_pend_q && cpu_oor_q;
   assign cpu_rdata  = (cpu_pend_q && !cpu_oor_q) ? mem_rdata : '0;
   assign ld_rvalid  = ld_pend_q;
   assign ld_rdata   = (ld_pend_q && !ld_oor_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_irom_access_arbiter.sv
// tb/tb_irom_access_arbiter.sv - randomized self-checking bench for irom_access_arbiter
module tb_irom_access_arbiter;
   localparam int SPACE = 4096;
   localparam int AW    = 12;
   localparam int BMAX  = 8;

   logic clk, rstn, boot_done, cpu_req, ld_req;
   logic [31:0] cpu_addr, ld_addr, ld_wdata, cpu_rdata, ld_rdata, mem_wdata, mem_rdata;
   logic [3:0] ld_we, mem_we;
   logic cpu_ready, cpu_rvalid, cpu_err, ld_ready, ld_rvalid, mem_cs;
   logic [AW-1:0] mem_addr;

   irom_access_arbiter #(.IROM_SPACE(SPACE), .LD_BURST_MAX(BMAX)) dut (
      .clk(clk), .rstn(rstn), .boot_done(boot_done),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ready(cpu_ready),
      .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_ready(ld_ready), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Sync RAM macro stand-in, one-cycle read latency.
   logic [31:0] ram [0:SPACE-1];
   logic [31:0] ram_q;
   bit          ram_init;
   assign mem_rdata = ram_q;

   function automatic logic [31:0] init_word(input int i);
      return (i * 32'h0101_0101) ^ 32'hA5A5_0000;
   endfunction

   always @(posedge clk) begin
      if (!ram_init) begin
         for (int i = 0; i < SPACE; i++) ram[i] <= init_word(i);
         ram_init <= 1'b1;
      end else if (mem_cs) begin
         if (mem_we == 4'h0) ram_q <= ram[mem_addr];
         else for (int b = 0; b < 4; b++)
            if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   int n_tests, n_fail, obs_cpu_gnts;
   logic [31:0] ref_mem [0:SPACE-1];
   bit m_run;
   int m_burst;
   bit e_cpu_rv, e_cpu_err, e_ld_rv;
   logic [31:0] e_cpu_rd, e_ld_rd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit inr(input logic [31:0] a);
      return (a >> (AW + 2)) == 0;
   endfunction

   function automatic int word_of(input logic [31:0] a);
      return int'((a >> 2) % SPACE);
   endfunction

   task automatic model_reset();
`ifdef IROM_BOOT_BYPASS_EN
      m_run = 1'b1;
`else
      m_run = 1'b0;
`endif
      m_burst = 0;
      e_cpu_rv = 0; e_cpu_err = 0; e_ld_rv = 0;
      e_cpu_rd = '0; e_ld_rd = '0;
   endtask

   task automatic comb_phase();
      bit cg, lg;
      logic x_cs;
      logic [3:0] x_we;
      logic [31:0] x_addr, x_wdata;
      int w;
      #1;
      cg = m_run && cpu_req && (!ld_req || m_burst == BMAX);
      lg = ld_req && !cg;
      x_cs = 0; x_we = 0; x_addr = 0; x_wdata = 0;
      if (cg && inr(cpu_addr)) begin x_cs = 1; x_addr = word_of(cpu_addr); end
      if (lg && inr(ld_addr)) begin
         x_cs = 1; x_we = ld_we; x_addr = word_of(ld_addr); x_wdata = ld_wdata;
      end
      chk("cpu_ready", cpu_ready, cg);
      chk("ld_ready", ld_ready, lg);
      chk("mem_cs", mem_cs, x_cs);
      chk("mem_we", mem_we, x_we);
      chk("mem_addr", mem_addr, x_addr);
      chk("mem_wdata", mem_wdata, x_wdata);
      if (cpu_ready) obs_cpu_gnts++;

      e_cpu_rv  = cg;
      e_cpu_err = cg && !inr(cpu_addr);
      e_cpu_rd  = (cg && inr(cpu_addr)) ? ref_mem[word_of(cpu_addr)] : '0;
      e_ld_rv   = lg && (ld_we == 0);
      e_ld_rd   = (e_ld_rv && inr(ld_addr)) ? ref_mem[word_of(ld_addr)] : '0;
      if (lg && ld_we != 0 && inr(ld_addr)) begin
         w = word_of(ld_addr);
         for (int b = 0; b < 4; b++) if (ld_we[b]) ref_mem[w][8*b +: 8] = ld_wdata[8*b +: 8];
      end
      if (m_run) begin
         if (cg || !cpu_req) m_burst = 0;
         else if (lg && m_burst < BMAX) m_burst++;
      end
`ifndef IROM_BOOT_BYPASS_EN
      if (boot_done) m_run = 1'b1;
`endif
   endtask

   task automatic reg_phase();
      @(negedge clk);
      chk("cpu_rvalid", cpu_rvalid, e_cpu_rv);
      chk("cpu_err", cpu_err, e_cpu_err);
      chk("cpu_rdata", cpu_rdata, e_cpu_rd);
      chk("ld_rvalid", ld_rvalid, e_ld_rv);
      chk("ld_rdata", ld_rdata, e_ld_rd);
   endtask

   task automatic step();
      comb_phase();
      reg_phase();
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      #1;
      model_reset();
      chk("rst_cpu_ready", cpu_ready, 0);
      chk("rst_ld_ready", ld_ready, 0);
      chk("rst_mem_cs", mem_cs, 0);
      @(negedge clk);
      chk("rst_cpu_rvalid", cpu_rvalid, 0);
      chk("rst_ld_rvalid", ld_rvalid, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      n_tests = 0; n_fail = 0; obs_cpu_gnts = 0;
      for (int i = 0; i < SPACE; i++) ref_mem[i] = init_word(i);
      rstn = 1'b0; boot_done = 0; cpu_req = 0; cpu_addr = 0;
      ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
      @(negedge clk);
      do_reset();

      // Boot hold-off, then boot_done with simultaneous cpu_req.
      cpu_req = 1; cpu_addr = 32'h0;
      repeat (10) step();
      boot_done = 1; step();
      boot_done = 0; step();

      // Loader write then readback.
      cpu_req = 0; ld_req = 1; ld_we = 4'hF; ld_addr = 32'h10; ld_wdata = 32'hDEAD_BEEF;
      step();
      ld_we = 4'h0; step();
      chk("ld_readback", ld_rdata, 32'hDEAD_BEEF);

      // Loader burst against a pending CPU fetch.
      ld_req = 0; step();
      ld_req = 1; ld_addr = 32'h40; cpu_req = 1; cpu_addr = 32'h20;
      obs_cpu_gnts = 0;
      repeat (27) step();
      chk("burst_pattern", obs_cpu_gnts, 3);

      // Out-of-range CPU fetch.
      ld_req = 0; cpu_addr = 32'h4000; step();
      chk("oor_err", cpu_err, 1);
      cpu_req = 0; step();

      // Reset while a CPU read is in flight.
      cpu_req = 1; cpu_addr = 32'h8;
      comb_phase();
      do_reset();
      step();
      cpu_req = 0; boot_done = 1; step();
      boot_done = 0;

      for (int n = 0; n < 600; n++) begin
         cpu_req  = ($urandom % 4) != 0;
         cpu_addr = ($urandom % 16 == 0) ? $urandom : $urandom_range(0, 255);
         ld_req   = ($urandom % 3) != 0;
         ld_addr  = ($urandom % 16 == 0) ? $urandom : $urandom_range(0, 255);
         ld_we    = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
         ld_wdata = $urandom;
         boot_done = ($urandom % 40) == 0;
         if ($urandom % 250 == 0) do_reset();
         else step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
